// File: rtl/memory_access_unit.sv
// ----------------------------------------------------------------------------
// memory_access_unit
//
// Memory-stage load/store engine. It sits between the execute/memory and the
// memory/writeback pipeline latches. The access latched in M becomes a
// request/ready handshake on the data-memory port, and the pipeline is stalled
// until that handshake completes.
//
// Stores get byte strobes and lane-replicated write data. Loads get their byte
// or halfword lane extracted and then sign- or zero-extended. A 16-bit
// wait-cycle counter aborts a request that never completes.
//
// Optional feature:
//   MEM_MISALIGN_TRAP_EN -- when defined, misaligned H/HU/W accesses are trapped:
//                           no request is issued and MisalignM pulses in DONE.
//                           When undefined, the low address bits are ignored
//                           for H and W, which forces the access aligned.
//
// Parameters:
//   TIMEOUT_CYCLES  maximum REQ cycles before a bus error (1..65535)
//
// Ports:
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   MemWriteM        store access in M
//   ResultSrcM       2'b01 marks a load
//   ALUResultM       byte address
//   WriteDataM       right-justified store data
//   funct3M          size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   mem_req          request valid, held until accepted
//   mem_we           1 = write
//   mem_addr         word-aligned address
//   mem_wdata        lane-replicated store data
//   mem_wstrb        byte enables (zero on reads)
//   mem_rdata        read word, valid with mem_ready
//   mem_ready        access accepted/completed this cycle
//   ReadDataM        extended load result, valid in DONE
//   StallM           holds the front of the pipeline through M
//   MisalignM        one-cycle misalignment flag (DONE only)
//   BusErrM          one-cycle timeout flag (DONE only)
// ----------------------------------------------------------------------------
module memory_access_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemWriteM,
    input  logic [1:0]  ResultSrcM,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    input  logic [2:0]  funct3M,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic [31:0] ReadDataM,
    output logic        StallM,
    output logic        MisalignM,
    output logic        BusErrM
);

    // The counter value seen in the last REQ cycle that may still wait. Reaching
    // it without ready ends REQ after exactly TIMEOUT_CYCLES cycles.
    localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        misalign_q, misalign_d;
    logic        buserr_q, buserr_d;

    logic        access;
    logic        is_byte;
    logic        is_half;
    logic        is_word;
    logic        is_unsigned;
    logic        misaligned;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] load_ext;
    logic [3:0]  wstrb;

    // ------------------------------------------------------------------------
    // Access decode
    // ------------------------------------------------------------------------
    assign access = MemWriteM | (ResultSrcM == 2'b01);

    // Size comes from funct3[1:0]. The undefined encodings 011, 110 and 111 all
    // fall through to word.
    assign is_byte     = (funct3M[1:0] == 2'b00);
    assign is_half     = (funct3M[1:0] == 2'b01);
    assign is_word     = ~is_byte & ~is_half;
    assign is_unsigned = funct3M[2];

`ifdef MEM_MISALIGN_TRAP_EN
    assign misaligned = (is_half & ALUResultM[0]) | (is_word & (ALUResultM[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Load lane extraction and extension
    // ------------------------------------------------------------------------
    always_comb begin
        byte_lane = mem_rdata[7:0];
        unique case (ALUResultM[1:0])
            2'b00: byte_lane = mem_rdata[7:0];
            2'b01: byte_lane = mem_rdata[15:8];
            2'b10: byte_lane = mem_rdata[23:16];
            2'b11: byte_lane = mem_rdata[31:24];
            default: byte_lane = mem_rdata[7:0];
        endcase
    end

    // addr[0] is ignored for halfwords, which forces the halfword aligned.
    assign half_lane = ALUResultM[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    always_comb begin
        load_ext = mem_rdata;
        if (is_byte) begin
            load_ext = {{24{~is_unsigned & byte_lane[7]}}, byte_lane};
        end else if (is_half) begin
            load_ext = {{16{~is_unsigned & half_lane[15]}}, half_lane};
        end
    end

    // ------------------------------------------------------------------------
    // Store strobes and lane-replicated write data
    // ------------------------------------------------------------------------
    always_comb begin
        wstrb     = 4'b1111;
        mem_wdata = WriteDataM;
        if (is_byte) begin
            wstrb     = 4'b0001 << ALUResultM[1:0];
            mem_wdata = {4{WriteDataM[7:0]}};
        end else if (is_half) begin
            wstrb     = 4'b0011 << {ALUResultM[1], 1'b0};
            mem_wdata = {2{WriteDataM[15:0]}};
        end
    end

    assign mem_wstrb = MemWriteM ? wstrb : 4'b0000;
    assign mem_we    = MemWriteM;
    assign mem_addr  = {ALUResultM[31:2], 2'b00};

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= 16'd0;
            rdata_q    <= 32'd0;
            misalign_q <= 1'b0;
            buserr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rdata_q    <= rdata_d;
            misalign_q <= misalign_d;
            buserr_q   <= buserr_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    // The flags default to 0 and are set only on the transition into DONE.
    // DONE always returns to IDLE, so each flag is high for exactly one cycle.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rdata_d    = rdata_q;
        misalign_d = 1'b0;
        buserr_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (access) begin
                    if (misaligned) begin
                        state_d    = StDone;
                        misalign_d = 1'b1;
                        rdata_d    = 32'd0;
                    end else begin
                        state_d = StReq;
                        cnt_d   = 16'd0;
                    end
                end
            end
            StReq: begin
                if (mem_ready) begin
                    state_d = StDone;
                    rdata_d = load_ext;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                    if (cnt_q >= TimeoutLast) begin
                        state_d  = StDone;
                        buserr_d = 1'b1;
                        rdata_d  = 32'd0;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    always_comb begin
        mem_req = 1'b0;
        StallM  = 1'b0;
        unique case (state_q)
            StIdle: StallM = access;
            StReq: begin
                mem_req = 1'b1;
                StallM  = 1'b1;
            end
            StDone: StallM = 1'b0;
            default: StallM = 1'b0;
        endcase
    end

    assign ReadDataM = rdata_q;
    assign MisalignM = misalign_q;
    assign BusErrM   = buserr_q;

endmodule

// File: tb/tb_memory_access_unit.sv
module tb_memory_access_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        MemWriteM;
    logic [1:0]  ResultSrcM;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic [2:0]  funct3M;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic [31:0] ReadDataM;
    logic        StallM;
    logic        MisalignM;
    logic        BusErrM;

    // Second instance with a short timeout, driven by its own access/handshake.
    logic [1:0]  to_rs;
    logic        to_req;
    logic        to_we;
    logic [31:0] to_addr;
    logic [31:0] to_wdata;
    logic [3:0]  to_wstrb;
    logic [31:0] to_rdata_in;
    logic        to_ready;
    logic [31:0] to_rd;
    logic        to_stall;
    logic        to_mis;
    logic        to_be;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    memory_access_unit #(.TIMEOUT_CYCLES(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .MemWriteM  (MemWriteM),
        .ResultSrcM (ResultSrcM),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .funct3M    (funct3M),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .ReadDataM  (ReadDataM),
        .StallM     (StallM),
        .MisalignM  (MisalignM),
        .BusErrM    (BusErrM)
    );

    memory_access_unit #(.TIMEOUT_CYCLES(4)) dut_to (
        .clk        (clk),
        .rst_n      (rst_n),
        .MemWriteM  (1'b0),
        .ResultSrcM (to_rs),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .funct3M    (funct3M),
        .mem_req    (to_req),
        .mem_we     (to_we),
        .mem_addr   (to_addr),
        .mem_wdata  (to_wdata),
        .mem_wstrb  (to_wstrb),
        .mem_rdata  (to_rdata_in),
        .mem_ready  (to_ready),
        .ReadDataM  (to_rd),
        .StallM     (to_stall),
        .MisalignM  (to_mis),
        .BusErrM    (to_be)
    );

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // ---------------- reference model (byte arithmetic) ----------------
    function automatic int acc_bytes(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            default:        return 4;
        endcase
    endfunction

    // Byte offset of the selected lane inside the word (access forced aligned).
    function automatic int lane_off(input logic [2:0] f3, input logic [31:0] addr);
        int n = acc_bytes(f3);
        int a = int'(addr % 4);
        return (a / n) * n;
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] rd);
        int     n = acc_bytes(f3);
        int     off = lane_off(f3, addr);
        longint span = longint'(1) << (8 * n);
        longint v = (longint'(rd) >> (8 * off)) % span;
        if (!f3[2] && n < 4 && v >= span / 2) v = v - span;
        return v[31:0];
    endfunction

    function automatic logic [3:0] exp_strb(input logic [2:0] f3, input logic [31:0] addr);
        int n = acc_bytes(f3);
        return 4'(((1 << n) - 1) << lane_off(f3, addr));
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] wd);
        int n = acc_bytes(f3);
        if (n == 1) return (wd % 256) * 32'h0101_0101;
        if (n == 2) return (wd % 65536) * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic exp_trap(input logic [2:0] f3, input logic [31:0] addr);
`ifdef MEM_MISALIGN_TRAP_EN
        int n = acc_bytes(f3);
        return (n > 1) && (addr % n != 0);
`else
        return (f3 == 3'b111) && (addr == 32'hFFFF_FFFF) && 1'b0;
`endif
    endfunction

    // One access from IDLE through DONE; ready is withheld for wait_n REQ cycles.
    task automatic run_access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                              input logic [2:0] f3, input logic [31:0] rd, input int wait_n);
        int   stalls = 0;
        int   reqs = 0;
        logic done = 1'b0;
        logic trap = exp_trap(f3, addr);
        MemWriteM  = we;
        ResultSrcM = we ? 2'b00 : 2'b01;
        ALUResultM = addr;
        WriteDataM = wd;
        funct3M    = f3;
        mem_ready  = 1'b0;
        mem_rdata  = $urandom;
        #1;
        chk32("mem_addr", mem_addr, addr & 32'hFFFF_FFFC);
        chk1("mem_we", mem_we, we);
        chk32("mem_wstrb", {28'd0, mem_wstrb}, {28'd0, we ? exp_strb(f3, addr) : 4'b0000});
        if (we) chk32("mem_wdata", mem_wdata, exp_wdata(f3, wd));
        for (int cyc = 0; cyc < 64 && !done; cyc++) begin
            if (StallM) stalls++;
            if (mem_req) begin
                reqs++;
                if (reqs == wait_n + 1) begin
                    mem_ready = 1'b1;
                    mem_rdata = rd;
                end else begin
                    mem_ready = 1'b0;
                    mem_rdata = $urandom;
                end
            end else begin
                // Ready outside REQ must be ignored.
                mem_ready = 1'($urandom_range(0, 1));
                mem_rdata = $urandom;
            end
            if (!StallM && cyc > 0) begin
                done = 1'b1;
                chk1("misalign_done", MisalignM, trap);
                chk1("buserr_done", BusErrM, 1'b0);
                if (!we || trap) chk32("read_data", ReadDataM, trap ? 32'd0 : exp_load(f3, addr, rd));
            end else begin
                chk1("misalign_idle", MisalignM, 1'b0);
                chk1("buserr_idle", BusErrM, 1'b0);
                @(posedge clk);
                #1;
            end
        end
        chk1("access_done", done, 1'b1);
        chk32("req_cycles", 32'(reqs), trap ? 32'd0 : 32'(wait_n + 1));
        chk32("stall_cycles", 32'(stalls), trap ? 32'd1 : 32'(wait_n + 2));
        @(posedge clk);
        #1;
        MemWriteM  = 1'b0;
        ResultSrcM = 2'b00;
        mem_ready  = 1'b0;
        #1;
        chk1("stall_after", StallM, 1'b0);
        chk1("req_after", mem_req, 1'b0);
    endtask

    initial begin
        logic done;
        int   reqs;
        int   stalls;
        rst_n       = 1'b0;
        MemWriteM   = 1'b0;
        ResultSrcM  = 2'b00;
        ALUResultM  = 32'd0;
        WriteDataM  = 32'd0;
        funct3M     = 3'b010;
        mem_rdata   = 32'd0;
        mem_ready   = 1'b0;
        to_rs       = 2'b00;
        to_rdata_in = 32'd0;
        to_ready    = 1'b0;

        // Reset state.
        #12;
        chk1("rst_req", mem_req, 1'b0);
        chk32("rst_rdata", ReadDataM, 32'd0);
        chk1("rst_mis", MisalignM, 1'b0);
        chk1("rst_be", BusErrM, 1'b0);
        chk1("rst_stall", StallM, 1'b0);
        ResultSrcM = 2'b01;
        #1;
        chk1("rst_stall_follows", StallM, 1'b1);
        chk1("rst_req_access", mem_req, 1'b0);
        ResultSrcM = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed cases.
        run_access(1'b0, 32'h0000_1003, 32'd0, 3'b000, 32'h80FF_7F01, 0);  // LB
        run_access(1'b0, 32'h0000_1002, 32'd0, 3'b101, 32'h8001_1234, 0);  // LHU
        run_access(1'b0, 32'h0000_1002, 32'd0, 3'b001, 32'h8001_1234, 1);  // LH
        run_access(1'b1, 32'h0000_2001, 32'h0000_00AB, 3'b000, 32'd0, 0);  // SB
        run_access(1'b1, 32'h0000_2002, 32'h1234_BEEF, 3'b001, 32'd0, 2);  // SH
        run_access(1'b1, 32'h0000_2004, 32'hCAFE_F00D, 3'b010, 32'd0, 0);  // SW
        run_access(1'b0, 32'h0000_1000, 32'd0, 3'b010, 32'h5A5A_A5A5, 5);  // LW, 5 waits
        run_access(1'b0, 32'h0000_3002, 32'd0, 3'b010, 32'h1357_9BDF, 0);  // LW misaligned
        run_access(1'b0, 32'h0000_100A, 32'd0, 3'b011, 32'h0F0E_0D0C, 0);  // undefined -> W
        run_access(1'b0, 32'h0000_1001, 32'd0, 3'b100, 32'h0000_F100, 0);  // LBU

        // Randomized accesses.
        for (int i = 0; i < 30; i++) begin
            run_access(1'($urandom_range(0, 1)), $urandom, $urandom, 3'($urandom_range(0, 7)),
                       $urandom, int'($urandom_range(0, 3)));
        end

        // Short-timeout instance: a successful load, then one that never completes.
        funct3M     = 3'b010;
        ALUResultM  = 32'h0000_4006;
        WriteDataM  = 32'h1234_5678;
        to_rs       = 2'b01;
        to_ready    = 1'b1;
        to_rdata_in = 32'hDEAD_BEEF;
        #1;
        chk1("to_stall_idle", to_stall, 1'b1);
        chk32("to_addr", to_addr, 32'h0000_4004);
        chk1("to_we", to_we, 1'b0);
        chk32("to_wstrb", {28'd0, to_wstrb}, 32'd0);
        chk32("to_wdata", to_wdata, 32'h1234_5678);
        @(posedge clk);
        #1;
        chk1("to_req_ok", to_req, 1'b1);
        @(posedge clk);
        #1;
        chk1("to_stall_done", to_stall, 1'b0);
        chk32("to_rd_ok", to_rd, 32'hDEAD_BEEF);
        chk1("to_mis_ok", to_mis, 1'b0);
        @(posedge clk);
        #1;
        to_ready = 1'b0;
        done     = 1'b0;
        reqs     = 0;
        stalls   = 0;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            if (to_stall) stalls++;
            if (to_req) reqs++;
            if (!to_stall && cyc > 0) begin
                done = 1'b1;
                chk1("to_be_done", to_be, 1'b1);
                chk32("to_rd_zero", to_rd, 32'd0);
            end else begin
                chk1("to_be_idle", to_be, 1'b0);
                @(posedge clk);
                #1;
            end
        end
        chk1("to_done", done, 1'b1);
        chk32("to_req_cycles", 32'(reqs), 32'd4);
        chk32("to_stall_cycles", 32'(stalls), 32'd5);
        to_rs = 2'b00;
        @(posedge clk);
        #1;
        chk1("to_be_after", to_be, 1'b0);

        // Reset in the second REQ cycle.
        run_access(1'b0, 32'h0000_5003, 32'd0, 3'b000, 32'h7700_0000, 0);  // leaves ReadDataM != 0
        ResultSrcM = 2'b01;
        funct3M    = 3'b010;
        ALUResultM = 32'h0000_5000;
        mem_ready  = 1'b0;
        @(posedge clk);
        #1;
        chk1("rr_req1", mem_req, 1'b1);
        @(posedge clk);
        #1;
        chk1("rr_req2", mem_req, 1'b1);
        rst_n = 1'b0;
        #1;
        chk1("rr_req_drop", mem_req, 1'b0);
        chk32("rr_rdata_clr", ReadDataM, 32'd0);
        ResultSrcM = 2'b00;
        mem_ready  = 1'b1;
        mem_rdata  = 32'hFFFF_FFFF;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk1("rr_req_idle", mem_req, 1'b0);
        chk1("rr_stall", StallM, 1'b0);
        chk32("rr_rdata_stale", ReadDataM, 32'd0);
        chk1("rr_be", BusErrM, 1'b0);
        mem_ready = 1'b0;
        run_access(1'b0, 32'h0000_1003, 32'd0, 3'b000, 32'h80FF_7F01, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no completion, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
